// File: rtl/rob_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : rob_mp_if
// Brief    : Allocation, writeback, commit and status bundle of the re-order buffer.
// Revision : 1.0
// ============================================================================
interface rob_mp_if #(
    parameter int IDX_W  = 5,
    parameter int NUM_WB = 3,
    parameter int XLEN   = 32,
    parameter int PRD_W  = 5
);
    logic                    flush_i;
    logic                    alloc_valid_i;
    logic                    alloc_ready_o;
    logic [PRD_W-1:0]        alloc_prd_addr_i;
    logic [XLEN-1:0]         alloc_pc_i;
    logic [XLEN-1:0]         alloc_inst_i;
    logic [IDX_W-1:0]        alloc_rob_idx_o;
    logic [NUM_WB-1:0]       wb_valid_i;
    logic [NUM_WB*IDX_W-1:0] wb_rob_idx_i;
    logic [NUM_WB*XLEN-1:0]  wb_value_i;
    logic [NUM_WB-1:0]       wb_exc_i;
    logic                    commit_valid_o;
    logic                    commit_ready_i;
    logic [XLEN-1:0]         commit_pc_o;
    logic [XLEN-1:0]         commit_inst_o;
    logic [PRD_W-1:0]        commit_prd_addr_o;
    logic [XLEN-1:0]         commit_value_o;
    logic                    commit_exc_o;
    logic [IDX_W:0]          count_o;
    logic                    empty_o;
    logic                    full_o;

    modport master (
        output flush_i, alloc_valid_i, alloc_prd_addr_i, alloc_pc_i, alloc_inst_i,
        output wb_valid_i, wb_rob_idx_i, wb_value_i, wb_exc_i, commit_ready_i,
        input  alloc_ready_o, alloc_rob_idx_o, commit_valid_o, commit_pc_o,
        input  commit_inst_o, commit_prd_addr_o, commit_value_o, commit_exc_o,
        input  count_o, empty_o, full_o
    );

    modport slave (
        input  flush_i, alloc_valid_i, alloc_prd_addr_i, alloc_pc_i, alloc_inst_i,
        input  wb_valid_i, wb_rob_idx_i, wb_value_i, wb_exc_i, commit_ready_i,
        output alloc_ready_o, alloc_rob_idx_o, commit_valid_o, commit_pc_o,
        output commit_inst_o, commit_prd_addr_o, commit_value_o, commit_exc_o,
        output count_o, empty_o, full_o
    );
endinterface
`default_nettype wire

// File: rtl/rob_mp.sv
`default_nettype none
// ============================================================================
// Module   : rob_mp
// Brief    : Parametrised re-order buffer, multi-port writeback, in-order commit.
// Revision : 1.0
// ============================================================================
module rob_mp #(
    parameter int NUM_ENTRIES = 32,
    parameter int IDX_W       = 5,
    parameter int NUM_WB      = 3,
    parameter int XLEN        = 32,
    parameter int PRD_W       = 5
) (
    input  logic     clk_i,
    input  logic     reset_i,
    rob_mp_if.slave  bus
);
    localparam logic [IDX_W:0] c_full_cnt = (IDX_W+1)'(NUM_ENTRIES);

    logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]         count_q, count_d;
    logic [NUM_ENTRIES-1:0] alloc_q, alloc_d, done_q, done_d, exc_q, exc_d;

    logic [XLEN-1:0]        pc_q    [NUM_ENTRIES];
    logic [XLEN-1:0]        inst_q  [NUM_ENTRIES];
    logic [XLEN-1:0]        value_q [NUM_ENTRIES];
    logic [PRD_W-1:0]       prd_q   [NUM_ENTRIES];

    logic                   w_clear, w_full, w_alloc_fire, w_commit_valid, w_commit_fire;
    logic [IDX_W-1:0]       w_wb_idx [NUM_WB];
    logic [NUM_WB-1:0]      w_wb_hit;

    assign w_clear        = reset_i | bus.flush_i;
    assign w_full         = (count_q == c_full_cnt);
    assign w_alloc_fire   = bus.alloc_valid_i & ~w_full & ~w_clear;
    assign w_commit_valid = alloc_q[head_q] & done_q[head_q];
    assign w_commit_fire  = w_commit_valid & bus.commit_ready_i & ~w_clear;

    // A writeback only lands on an entry that is allocated before this edge.
    for (genvar p = 0; p < NUM_WB; p++) begin : g_wb_port
        assign w_wb_idx[p] = bus.wb_rob_idx_i[p*IDX_W +: IDX_W];
        assign w_wb_hit[p] = bus.wb_valid_i[p] & alloc_q[w_wb_idx[p]] & ~w_clear;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        alloc_d = alloc_q;
        done_d  = done_q;
        exc_d   = exc_q;
        if (w_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            alloc_d = '0;
            done_d  = '0;
            exc_d   = '0;
        end else begin
            // Ascending port order lets the highest port win on a shared index.
            for (int p = 0; p < NUM_WB; p++) begin
                if (w_wb_hit[p]) begin
                    done_d[w_wb_idx[p]] = 1'b1;
                    exc_d[w_wb_idx[p]]  = bus.wb_exc_i[p];
                end
            end
            if (w_alloc_fire) begin
                alloc_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                exc_d[tail_q]   = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            if (w_commit_fire) begin
                alloc_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
            end
            if (w_alloc_fire && !w_commit_fire) begin
                count_d = count_q + (IDX_W+1)'(1);
            end else if (!w_alloc_fire && w_commit_fire) begin
                count_d = count_q - (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_alloc_fire) begin
            pc_q[tail_q]   <= bus.alloc_pc_i;
            inst_q[tail_q] <= bus.alloc_inst_i;
            prd_q[tail_q]  <= bus.alloc_prd_addr_i;
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (w_wb_hit[p]) begin
                value_q[w_wb_idx[p]] <= bus.wb_value_i[p*XLEN +: XLEN];
            end
        end
    end

    assign bus.alloc_ready_o     = ~w_full;
    assign bus.alloc_rob_idx_o   = tail_q;
    assign bus.commit_valid_o    = w_commit_valid;
    assign bus.commit_pc_o       = pc_q[head_q];
    assign bus.commit_inst_o     = inst_q[head_q];
    assign bus.commit_prd_addr_o = prd_q[head_q];
    assign bus.commit_value_o    = value_q[head_q];
    assign bus.commit_exc_o      = exc_q[head_q];
    assign bus.count_o           = count_q;
    assign bus.empty_o           = (count_q == '0);
    assign bus.full_o            = w_full;
endmodule
`default_nettype wire

// File: tb/tb_rob_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_mp
// Brief    : Directed and randomised checks of rob_mp against a queue model.
// Revision : 1.0
// ============================================================================
module tb_rob_mp;
    localparam int N  = 32;
    localparam int IW = 5;
    localparam int NW = 3;
    localparam int XL = 32;
    localparam int PW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_mp_if #(.IDX_W(IW), .NUM_WB(NW), .XLEN(XL), .PRD_W(PW)) bus ();

    rob_mp #(.NUM_ENTRIES(N), .IDX_W(IW), .NUM_WB(NW), .XLEN(XL), .PRD_W(PW)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic [XL-1:0] pc;
        logic [XL-1:0] inst;
        logic [PW-1:0] prd;
        bit            done;
        bit            exc;
        logic [XL-1:0] value;
    } ent_t;

    ent_t          mq[$];
    logic [IW-1:0] mtail = '0;
    int            checks = 0;
    int            errors = 0;

    task automatic clear_inputs();
        bus.flush_i          = 1'b0;
        bus.alloc_valid_i    = 1'b0;
        bus.alloc_prd_addr_i = '0;
        bus.alloc_pc_i       = '0;
        bus.alloc_inst_i     = '0;
        bus.wb_valid_i       = '0;
        bus.wb_rob_idx_i     = '0;
        bus.wb_value_i       = '0;
        bus.wb_exc_i         = '0;
        bus.commit_ready_i   = 1'b0;
    endtask

    task automatic set_wb(input int p, input logic [IW-1:0] idx, input logic [XL-1:0] val, input logic exc);
        bus.wb_valid_i[p]              = 1'b1;
        bus.wb_rob_idx_i[p*IW +: IW]   = idx;
        bus.wb_value_i[p*XL +: XL]     = val;
        bus.wb_exc_i[p]                = exc;
    endtask

    task automatic set_alloc(input logic [XL-1:0] pc);
        bus.alloc_valid_i    = 1'b1;
        bus.alloc_pc_i       = pc;
        bus.alloc_inst_i     = pc ^ 32'hDEAD_0000;
        bus.alloc_prd_addr_i = pc[6:2];
    endtask

    // Model step from the inputs present just before the edge.
    task automatic model_clock();
        bit   fa, fc;
        ent_t e;
        if (rst || bus.flush_i) begin
            mq.delete();
            mtail = '0;
            return;
        end
        fa = bus.alloc_valid_i && (mq.size() < N);
        fc = bus.commit_ready_i && (mq.size() > 0) && mq[0].done;
        for (int p = 0; p < NW; p++) begin
            if (bus.wb_valid_i[p]) begin
                for (int k = 0; k < mq.size(); k++) begin
                    if (mq[k].idx == bus.wb_rob_idx_i[p*IW +: IW]) begin
                        mq[k].done  = 1'b1;
                        mq[k].exc   = bus.wb_exc_i[p];
                        mq[k].value = bus.wb_value_i[p*XL +: XL];
                    end
                end
            end
        end
        if (fc) void'(mq.pop_front());
        if (fa) begin
            e.idx = mtail; e.pc = bus.alloc_pc_i; e.inst = bus.alloc_inst_i;
            e.prd = bus.alloc_prd_addr_i; e.done = 1'b0; e.exc = 1'b0; e.value = '0;
            mq.push_back(e);
            mtail = mtail + 1'b1;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.alloc_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.alloc_ready_o); end
        checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty_o); end
        checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full_o); end
        checks++; if (bus.commit_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cvalid got %b exp 0", bus.commit_valid_o); end
        checks++; if (bus.count_o !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count_o); end
        checks++; if (bus.alloc_rob_idx_o !== 5'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bus.alloc_rob_idx_o); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(32'h100 + 32'(i*4));
            #1;
            checks++; if (bus.alloc_rob_idx_o !== 5'(i)) begin errors++; $display("FAIL basic_alloc_idx got %0d exp %0d", bus.alloc_rob_idx_o, i); end
            tick();
        end
        clear_inputs();
        #1;
        checks++; if (bus.count_o !== 6'd3) begin errors++; $display("FAIL basic_count3 got %0d exp 3", bus.count_o); end
        checks++; if (bus.commit_valid_o !== 1'b0) begin errors++; $display("FAIL basic_cvalid0 got %b exp 0", bus.commit_valid_o); end
        set_wb(0, 5'd1, 32'h11, 1'b0);
        tick();
        clear_inputs();
        set_wb(1, 5'd0, 32'h22, 1'b0);
        bus.commit_ready_i = 1'b1;
        #1;
        checks++; if (bus.commit_valid_o !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got %b exp 0", bus.commit_valid_o); end
        tick();
        bus.wb_valid_i = '0;
        #1;
        checks++; if (bus.commit_valid_o !== 1'b1 || bus.commit_pc_o !== 32'h100) begin errors++; $display("FAIL basic_commit0 got v=%b pc=%h exp v=1 pc=100", bus.commit_valid_o, bus.commit_pc_o); end
        checks++; if (bus.commit_value_o !== 32'h22) begin errors++; $display("FAIL basic_value0 got %h exp 22", bus.commit_value_o); end
        tick();
        checks++; if (bus.commit_valid_o !== 1'b1 || bus.commit_pc_o !== 32'h104) begin errors++; $display("FAIL basic_commit1 got v=%b pc=%h exp v=1 pc=104", bus.commit_valid_o, bus.commit_pc_o); end
        tick();
        checks++; if (bus.commit_valid_o !== 1'b0 || bus.count_o !== 6'd1) begin errors++; $display("FAIL basic_after got v=%b cnt=%0d exp v=0 cnt=1", bus.commit_valid_o, bus.count_o); end
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_alloc(32'h1000 + 32'(i*4));
            tick();
        end
        clear_inputs();
        #1;
        checks++; if (bus.full_o !== 1'b1 || bus.alloc_ready_o !== 1'b0 || bus.count_o !== 6'd32) begin errors++; $display("FAIL full_flags got full=%b rdy=%b cnt=%0d exp 1 0 32", bus.full_o, bus.alloc_ready_o, bus.count_o); end
        set_wb(2, 5'd0, 32'h77, 1'b0);
        tick();
        clear_inputs();
        set_alloc(32'h2000);
        bus.commit_ready_i = 1'b1;
        #1;
        checks++; if (bus.alloc_ready_o !== 1'b0 || bus.commit_valid_o !== 1'b1) begin errors++; $display("FAIL full_refuse got rdy=%b cv=%b exp 0 1", bus.alloc_ready_o, bus.commit_valid_o); end
        tick();
        bus.commit_ready_i = 1'b0;
        #1;
        checks++; if (bus.count_o !== 6'd31 || bus.alloc_rob_idx_o !== 5'd0) begin errors++; $display("FAIL full_commit got cnt=%0d idx=%0d exp 31 0", bus.count_o, bus.alloc_rob_idx_o); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.count_o !== 6'd32 || bus.full_o !== 1'b1 || bus.alloc_rob_idx_o !== 5'd1) begin errors++; $display("FAIL full_realloc got cnt=%0d full=%b idx=%0d exp 32 1 1", bus.count_o, bus.full_o, bus.alloc_rob_idx_o); end
    endtask

    task automatic test_wb_conflict();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_alloc(32'h300 + 32'(i*4));
            tick();
        end
        clear_inputs();
        set_wb(0, 5'd5, 32'hAAAA, 1'b0);
        set_wb(1, 5'd20, 32'h2020, 1'b1);
        set_wb(2, 5'd5, 32'hBBBB, 1'b0);
        tick();
        clear_inputs();
        set_wb(0, 5'd0, 32'h0, 1'b0); set_wb(1, 5'd1, 32'h1, 1'b0); set_wb(2, 5'd2, 32'h2, 1'b0);
        tick();
        clear_inputs();
        set_wb(0, 5'd3, 32'h3, 1'b0); set_wb(2, 5'd4, 32'h4, 1'b0);
        tick();
        clear_inputs();
        bus.commit_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (bus.commit_valid_o !== 1'b1 || bus.commit_value_o !== 32'hBBBB || bus.commit_pc_o !== 32'h314) begin errors++; $display("FAIL wb_highest got v=%b val=%h pc=%h exp 1 bbbb 314", bus.commit_valid_o, bus.commit_value_o, bus.commit_pc_o); end
        tick();
        bus.commit_ready_i = 1'b0;
        for (int i = 6; i <= 20; i++) begin
            set_alloc(32'h400 + 32'(i*4));
            tick();
        end
        clear_inputs();
        bus.commit_ready_i = 1'b1;
        for (int i = 6; i < 20; i++) begin
            set_wb(0, 5'(i), 32'(i), 1'b0);
            tick();
        end
        bus.wb_valid_i = '0;
        for (int i = 0; i < 16; i++) tick();
        checks++; if (bus.count_o !== 6'd1 || bus.commit_valid_o !== 1'b0) begin errors++; $display("FAIL wb_unalloc got cnt=%0d cv=%b exp 1 0", bus.count_o, bus.commit_valid_o); end
        clear_inputs();
    endtask

    task automatic test_exc();
        do_reset();
        set_alloc(32'h200); tick();
        set_alloc(32'h204); tick();
        clear_inputs();
        set_wb(1, 5'd0, 32'h55, 1'b1);
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.commit_valid_o !== 1'b1 || bus.commit_exc_o !== 1'b1 || bus.commit_pc_o !== 32'h200) begin errors++; $display("FAIL exc_head got v=%b exc=%b pc=%h exp 1 1 200", bus.commit_valid_o, bus.commit_exc_o, bus.commit_pc_o); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_alloc(32'h500 + 32'(i*4));
            tick();
        end
        clear_inputs();
        set_wb(0, 5'd0, 32'h9, 1'b0);
        tick();
        clear_inputs();
        bus.flush_i = 1'b1;
        set_alloc(32'h600);
        set_wb(2, 5'd3, 32'h3, 1'b0);
        bus.commit_ready_i = 1'b1;
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.count_o !== 6'd0 || bus.empty_o !== 1'b1 || bus.commit_valid_o !== 1'b0 || bus.alloc_rob_idx_o !== 5'd0) begin errors++; $display("FAIL flush_state got cnt=%0d empty=%b cv=%b idx=%0d exp 0 1 0 0", bus.count_o, bus.empty_o, bus.commit_valid_o, bus.alloc_rob_idx_o); end
        set_wb(0, 5'd0, 32'hF0, 1'b1);
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.count_o !== 6'd0 || bus.commit_valid_o !== 1'b0) begin errors++; $display("FAIL flush_late_wb got cnt=%0d cv=%b exp 0 0", bus.count_o, bus.commit_valid_o); end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            clear_inputs();
            if ($urandom_range(0, 99) < 70) set_alloc($urandom());
            bus.commit_ready_i = ($urandom_range(0, 99) < 55);
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 99) < 45) begin
                    if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                        set_wb(p, mq[$urandom_range(0, mq.size()-1)].idx, $urandom(), 1'($urandom_range(0, 1)));
                    else
                        set_wb(p, 5'($urandom_range(0, N-1)), $urandom(), 1'($urandom_range(0, 1)));
                end
            end
            bus.flush_i = ($urandom_range(0, 199) == 0);
            #1;
            n = mq.size();
            checks++; if (bus.count_o !== 6'(n)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, bus.count_o, n); end
            checks++; if (bus.empty_o !== (n == 0) || bus.full_o !== (n == N) || bus.alloc_ready_o !== (n < N)) begin errors++; $display("FAIL rnd_flags cyc %0d got e=%b f=%b r=%b exp cnt %0d", cyc, bus.empty_o, bus.full_o, bus.alloc_ready_o, n); end
            checks++; if (bus.alloc_rob_idx_o !== mtail) begin errors++; $display("FAIL rnd_idx cyc %0d got %0d exp %0d", cyc, bus.alloc_rob_idx_o, mtail); end
            checks++; if (bus.commit_valid_o !== (n > 0 && mq[0].done)) begin errors++; $display("FAIL rnd_cvalid cyc %0d got %b exp %b", cyc, bus.commit_valid_o, (n > 0 && mq[0].done)); end
            if (n > 0 && mq[0].done) begin
                checks++;
                if (bus.commit_pc_o !== mq[0].pc || bus.commit_inst_o !== mq[0].inst || bus.commit_prd_addr_o !== mq[0].prd ||
                    bus.commit_value_o !== mq[0].value || bus.commit_exc_o !== mq[0].exc) begin
                    errors++;
                    $display("FAIL rnd_commit cyc %0d got pc=%h val=%h exc=%b prd=%0d exp pc=%h val=%h exc=%b prd=%0d", cyc,
                             bus.commit_pc_o, bus.commit_value_o, bus.commit_exc_o, bus.commit_prd_addr_o,
                             mq[0].pc, mq[0].value, mq[0].exc, mq[0].prd);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_full();
        test_wb_conflict();
        test_exc();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rob_mp.md
Name: rob_mp

Overview:
- Parametrised re-order buffer: successor to the single-issue ROB. Configurable depth, writeback port count and data widths.
- Adds a valid/ready allocation and commit handshake, true full/empty/occupancy tracking, per-entry exception flag and a pipeline flush.
- Sits between dispatch (allocation), the execution units (writeback) and the architectural commit/free-list logic.

Parameters:
NUM_ENTRIES, 32, ROB depth; power of 2, ≥4
IDX_W, 5, log2(NUM_ENTRIES)
NUM_WB, 3, number of writeback ports (alu, lsu, mul by default)
XLEN, 32, data/pc/inst width
PRD_W, 5, physical destination register address width

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  synchronous active-high reset
flush_i  in  1  discard all entries
alloc_valid_i  in  1  dispatch requests an entry
alloc_ready_o  out  1  entry available (= !full_o)
alloc_prd_addr_i  in  PRD_W  destination phys reg
alloc_pc_i  in  XLEN  instruction pc
alloc_inst_i  in  XLEN  instruction word
alloc_rob_idx_o  out  IDX_W  index given to the allocating instruction (= tail)
wb_valid_i  in  NUM_WB  per-port writeback strobe
wb_rob_idx_i  in  NUM_WB*IDX_W  packed entry indices, port p at [p*IDX_W +: IDX_W]
wb_value_i  in  NUM_WB*XLEN  packed results
wb_exc_i  in  NUM_WB  per-port exception flag
commit_valid_o  out  1  head entry is complete
commit_ready_i  in  1  commit stage accepts head
commit_pc_o  out  XLEN  head pc
commit_inst_o  out  XLEN  head instruction word
commit_prd_addr_o  out  PRD_W  head destination
commit_value_o  out  XLEN  head result
commit_exc_o  out  1  head exception flag
count_o  out  IDX_W+1  occupancy, 0..NUM_ENTRIES
empty_o  out  1  count_o == 0
full_o  out  1  count_o == NUM_ENTRIES

Behaviour:
- State: head and tail pointers (IDX_W bits, natural wrap), count (IDX_W+1 bits). Per entry: allocated, done, exc, pc, inst, prd, value.
- Reset: head=tail=0, count=0, all allocated/done/exc=0. Payload arrays are not cleared.
  - Outputs after reset: alloc_ready_o=1, empty_o=1, full_o=0, commit_valid_o=0, count_o=0, alloc_rob_idx_o=0.
- Allocation fires when alloc_valid_i && alloc_ready_o.
  - On the edge: writes pc/inst/prd at tail, sets allocated=1, clears done/exc, tail+1.
  - alloc_rob_idx_o is valid in the same cycle as the request, before the edge.
- alloc_ready_o depends only on registered state. When full, allocation is refused even if a commit happens in the same cycle.
- Writeback on port p with wb_valid_i[p]: on the edge, entry idx gets done=1, exc=wb_exc_i[p], value=wb_value_i[p].
  - Writeback to an entry with allocated=0 is ignored.
  - If several ports target the same idx in one cycle, the highest port number wins.
  - Writebacks to distinct indices in the same cycle all take effect.
- Commit:
  - commit_valid_o = allocated[head] && done[head]. All commit_* data outputs are combinational reads of the head entry.
  - Fires when commit_valid_o && commit_ready_i: clears allocated/done at head, head+1.
  - At most one commit per cycle, strictly in order. An incomplete head blocks younger completed entries.
- Occupancy: count +1 on allocate only, -1 on commit only, unchanged when both or neither fire.
  - Pointers wrap NUM_ENTRIES-1 → 0. head==tail is disambiguated by count.
- Allocation and writeback to the tail index in the same cycle: the writeback is ignored because the entry is not yet allocated. No forwarding.
- Writeback to the head entry in the cycle it becomes done: commit_valid_o rises the following cycle. There is no same-cycle bypass.
- commit_exc_o is informational. The ROB does not self-flush; upstream asserts flush_i.
- flush_i (synchronous): same state effect as reset.
  - Overrides allocation, writeback and commit in the same cycle; nothing fires in that cycle, even if alloc_valid_i/commit_ready_i are high.
  - Reset has priority over flush.
- Reset or flush mid-operation discards all in-flight entries. Late writebacks to discarded indices are ignored until those indices are reallocated.

Test Plan:
- Reset, then allocate 3 entries (pc 0x100/0x104/0x108) → alloc_rob_idx_o 0,1,2; count_o=3; commit_valid_o=0.
- Writeback idx 1 then idx 0 → commit pc 0x100 then 0x104 on consecutive cycles with commit_ready_i=1; idx 2 is not committed; count_o=1.
- Fill all 32 entries → full_o=1, alloc_ready_o=0. With alloc_valid_i=1 and a commit in the same cycle → count_o=31 and tail unchanged. Next cycle the allocation succeeds; the tail wraps to 0 and then idx 0 is reallocated.
- Ports 0 and 2 both write idx 5 (values 0xAAAA/0xBBBB) in one cycle → committed value 0xBBBB. Writeback to an unallocated idx 20 → no effect.
- Writeback with wb_exc_i=1 at head → commit_exc_o=1 with the matching pc.
- flush_i asserted with 10 entries live plus simultaneous alloc/wb/commit → next cycle count_o=0, empty_o=1, commit_valid_o=0. A later writeback to an old idx is ignored.
